// File: rtl/beat_tempo_tracker.sv
// beat_tempo_tracker: one-shot beat events with holdoff, ms interval timing and 4-interval mean tempo.
// Define BEAT_TEMPO_LOCK_EN to build the steady-tempo comparator; otherwise tempo_lock is tied low.
module beat_tempo_tracker #(
  parameter int TICK_DIV   = 50000,
  parameter int HOLDOFF_MS = 150,
  parameter int TIMEOUT_MS = 2000,
  parameter int PERIOD_W   = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                beat_en,
  input  logic [1:0]          beat_intensity,
  output logic                beat_pulse,
  output logic [1:0]          pulse_intensity,
  output logic [PERIOD_W-1:0] period_ms,
  output logic                period_valid,
  output logic                tempo_lock
);
  localparam int PSW = $clog2(TICK_DIV + 1);
  localparam int HW  = $clog2(HOLDOFF_MS + 1);
  localparam int SW  = PERIOD_W + 2;
  localparam logic [1:0] IDLE = 2'd0, FIRST = 2'd1, TRACK = 2'd2;
  logic [PSW-1:0]      presc_q, presc_d;
  logic                beat_d_q, beat_d_d;
  logic [HW-1:0]       holdoff_q, holdoff_d;
  logic [1:0]          state_q, state_d;
  logic [PERIOD_W-1:0] ivl_q, ivl_d;
  logic [PERIOD_W-1:0] hist_q [4];
  logic [PERIOD_W-1:0] hist_d [4];
  logic [2:0]          cnt_q, cnt_d;
  logic                pulse_q, pulse_d;
  logic [1:0]          pint_q, pint_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                valid_q, valid_d;
  logic                tick, rise, accept, timeout, push;
  logic [SW-1:0]       sum;
  always_comb begin
    tick      = presc_q == PSW'(TICK_DIV - 1);
    presc_d   = tick ? '0 : presc_q + PSW'(1);
    beat_d_d  = beat_en;
    rise      = beat_en & ~beat_d_q;
    accept    = rise & (holdoff_q == '0);
    timeout   = (state_q != IDLE) & (ivl_q == PERIOD_W'(TIMEOUT_MS));
    push      = accept & (state_q != IDLE) & ~timeout;
    holdoff_d = accept ? HW'(HOLDOFF_MS) : holdoff_q - HW'(tick && holdoff_q != '0);
    // a beat coinciding with timeout restarts tracking from scratch
    state_d   = accept ? ((state_q == IDLE || timeout) ? FIRST : TRACK) : (timeout ? IDLE : state_q);
    ivl_d     = (accept || timeout) ? '0 : (tick && state_q != IDLE) ? ivl_q + PERIOD_W'(1) : ivl_q;
    hist_d[0] = timeout ? '0 : push ? ivl_q : hist_q[0];
    for (int i = 1; i < 4; i++)
      hist_d[i] = timeout ? '0 : push ? hist_q[i-1] : hist_q[i];
    cnt_d     = timeout ? 3'd0 : (push && cnt_q != 3'd4) ? cnt_q + 3'd1 : cnt_q;
    sum       = SW'(hist_q[0]) + SW'(hist_q[1]) + SW'(hist_q[2]) + SW'(hist_q[3]);
    period_d  = timeout ? '0 : PERIOD_W'(sum >> 2);
    valid_d   = ~timeout & (cnt_q == 3'd4);
    pulse_d   = accept;
    pint_d    = accept ? beat_intensity : pint_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q   <= '0;
      beat_d_q  <= 1'b1;
      holdoff_q <= '0;
      state_q   <= IDLE;
      ivl_q     <= '0;
      hist_q    <= '{default: '0};
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      pint_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      beat_d_q  <= beat_d_d;
      holdoff_q <= holdoff_d;
      state_q   <= state_d;
      ivl_q     <= ivl_d;
      hist_q    <= hist_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      pint_q    <= pint_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
    end
  end
  assign beat_pulse      = pulse_q;
  assign pulse_intensity = pint_q;
  assign period_ms       = period_q;
  assign period_valid    = valid_q;
`ifdef BEAT_TEMPO_LOCK_EN
  logic                lock_q, lock_d, band;
  logic [PERIOD_W-1:0] tol;
  always_comb begin
    tol  = period_q >> 3;
    band = 1'b1;
    for (int i = 0; i < 4; i++)
      band = band & ({1'b0, hist_q[i]} + {1'b0, tol} >= {1'b0, period_q})
                  & ({1'b0, hist_q[i]} <= {1'b0, period_q} + {1'b0, tol});
    lock_d = ~timeout & valid_q & band;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lock_q <= 1'b0;
    else      lock_q <= lock_d;
  end
  assign tempo_lock = lock_q;
`else
  assign tempo_lock = 1'b0;
`endif
endmodule

// File: tb/tb_beat_tempo_tracker.sv
// tb_beat_tempo_tracker: randomized beats against a queue-based tempo model, plus directed boundary checks.
module tb_beat_tempo_tracker;
  localparam int TD = 10, HO = 150, TO = 2000, PW = 12;
`ifdef BEAT_TEMPO_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  logic          clk = 1'b0, rst = 1'b0, beat_en = 1'b0;
  logic [1:0]    beat_intensity = 2'd0;
  logic          beat_pulse, period_valid, tempo_lock;
  logic [1:0]    pulse_intensity;
  logic [PW-1:0] period_ms;
  int n_run = 0, n_fail = 0, pcnt = 0, p0;
  int m_cyc, m_ms, q[$];
  bit m_prev, m_active, e_pulse, e_valid, e_lock;
  logic [1:0] e_pint;
  int e_period;

  beat_tempo_tracker #(.TICK_DIV(TD), .HOLDOFF_MS(HO), .TIMEOUT_MS(TO), .PERIOD_W(PW)) dut (
    .clk(clk), .rst(rst), .beat_en(beat_en), .beat_intensity(beat_intensity),
    .beat_pulse(beat_pulse), .pulse_intensity(pulse_intensity), .period_ms(period_ms),
    .period_valid(period_valid), .tempo_lock(tempo_lock)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_cyc = 0; m_ms = HO; q.delete(); m_prev = 1'b1; m_active = 1'b0;
    e_pulse = 1'b0; e_pint = 2'd0; e_period = 0; e_valid = 1'b0; e_lock = 1'b0;
  endtask

  // One clock of the tempo rules: ms since last accepted beat drives holdoff, interval and timeout.
  task automatic m_step();
    bit tick, acc, tmo, band;
    int s, d;
    tick = (m_cyc % TD) == TD - 1;
    acc  = beat_en && !m_prev && m_ms >= HO;
    tmo  = m_active && m_ms >= TO;
    band = 1'b1; s = 0;
    foreach (q[i]) begin
      s += q[i];
      d = q[i] - e_period;
      if (d < 0) d = -d;
      if (d > e_period / 8) band = 1'b0;
    end
    e_lock   = LOCK && !tmo && e_valid && band;
    e_period = tmo ? 0 : s / 4;
    e_valid  = !tmo && q.size() == 4;
    if (tmo) q.delete();
    else if (acc && m_active) begin
      q.push_front(m_ms);
      if (q.size() > 4) void'(q.pop_back());
    end
    if (acc) m_active = 1'b1; else if (tmo) m_active = 1'b0;
    e_pulse = acc;
    if (acc) e_pint = beat_intensity;
    if (acc) m_ms = 0; else if (tick && m_ms < 100000) m_ms++;
    m_prev = beat_en;
    m_cyc++;
  endtask

  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_reset();
        check("reset_outs", {beat_pulse, pulse_intensity, period_ms, period_valid, tempo_lock}, 0);
      end else begin
        check("outs", {beat_pulse, pulse_intensity, period_ms, period_valid, tempo_lock},
              {e_pulse, e_pint, PW'(e_period), e_valid, e_lock});
        if (beat_pulse) pcnt++;
        m_step();
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input int gap, input int hi, input logic [1:0] inten);
    beat_intensity = inten; beat_en = 1'b1; cyc(hi);
    beat_en = 1'b0; cyc(gap - hi);
  endtask

  initial begin
    beat_en = 1'b1;
    cyc(3);
    rst = 1'b1;
    p0 = pcnt; cyc(50);
    check("high_at_release", pcnt - p0, 0);
    beat_en = 1'b0; cyc(5);
    p0 = pcnt; beat(3005, 3000, 2'd2);
    check("long_level_one_pulse", pcnt - p0, 1);
    check("long_level_int", pulse_intensity, 2);
    p0 = pcnt; beat(1000, 5, 2'd1);
    check("beat_a", pcnt - p0, 1);
    p0 = pcnt; beat(600, 5, 2'd3);
    check("holdoff_100ms", pcnt - p0, 0);
    check("holdoff_int_kept", pulse_intensity, 1);
    p0 = pcnt; beat(20, 5, 2'd2);
    check("after_160ms", pcnt - p0, 1);
    rst = 1'b0; cyc(1);
    check("mid_reset", {beat_pulse, pulse_intensity, period_ms, period_valid, tempo_lock}, 0);
    rst = 1'b1; cyc(5);
    for (int i = 0; i < 4; i++) beat(5000, $urandom_range(1, 50), 2'($urandom_range(0, 3)));
    check("valid_before_5th", period_valid, 0);
    beat(5000, $urandom_range(1, 50), 2'd1);
    check("valid_after_5th", period_valid, 1);
    check("period_500", (period_ms == 499 || period_ms == 500), 1);
    check("lock_steady", tempo_lock, LOCK);
    cyc(2000);
    beat(50, 3, 2'd3);
    check("avg_550", (period_ms >= 548 && period_ms <= 550), 1);
    check("lock_700", tempo_lock, 0);
    cyc(20500);
    check("timeout_valid", period_valid, 0);
    check("timeout_period", period_ms, 0);
    check("timeout_lock", tempo_lock, 0);
    check("timeout_int_held", pulse_intensity, 3);
    p0 = pcnt; beat(50, 2, 2'd1);
    check("beat_after_timeout", pcnt - p0, 1);
    check("first_no_period", period_ms, 0);
    for (int i = 0; i < 12; i++) begin
      int g;
      g = $urandom_range(100, 3500);
      beat(g, $urandom_range(1, g - 1), 2'($urandom_range(0, 3)));
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
